axi4m_burst: RTL
================

Name: axi4m_burst

Overview:
- Second-generation native-to-AXI4 master bridge for the core and cache refill/writeback path.
- Accepts one native request at a time and issues a single AXI4 INCR or WRAP burst of 1..MAX_BEATS beats.
- Streams write data in and read data out beat by beat with full backpressure on both sides.
- Unlike the single-beat bridge: AW and W proceed concurrently, the burst length and type are set per request, and AXI errors and beat-count mismatches are reported back to the requester.

Parameters:
- AXI_ADDR_W, 32, address width.
- AXI_DATA_W, 32, data width; must be 32, 64 or 128.
- MAX_BEATS, 16, maximum beats per burst; power of 2, at most 256.
- LEN_W, 4, req_len width; equals log2(MAX_BEATS).

Ports:
- clk  in  1  clock; all logic on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- req_val  in  1  native request valid.
- req_rdy  out  1  bridge idle; the request is accepted on req_val&req_rdy.
- req_adr  in  AXI_ADDR_W  burst start address, aligned to the beat size.
- req_wr  in  1  1 = write, 0 = read.
- req_len  in  LEN_W  number of beats minus 1.
- req_wrap  in  1  1 = WRAP burst, 0 = INCR burst.
- wd_val / wd_rdy  in / out  1 / 1  write-beat handshake.
- wd_dat / wd_stb  in  AXI_DATA_W / AXI_DATA_W/8  write-beat data and byte strobes.
- rd_val / rd_rdy  out / in  1 / 1  read-beat handshake.
- rd_dat / rd_last  out  AXI_DATA_W / 1  read-beat data and last-beat flag.
- done  out  1  one-cycle pulse at transaction completion.
- err  out  1  error status, valid only while done=1.
- m_axi_aw{addr,len,size,burst}  out  AXI_ADDR_W/8/3/2  write address channel.
- m_axi_aw{valid,ready}  out/in  1/1  write address handshake.
- m_axi_w{data,strb,last}  out  AXI_DATA_W/AXI_DATA_W/8/1  write data channel.
- m_axi_w{valid,ready}  out/in  1/1  write data handshake.
- m_axi_b{resp,valid}  in  2/1  write response.
- m_axi_bready  out  1  write response ready.
- m_axi_ar{addr,len,size,burst}  out  AXI_ADDR_W/8/3/2  read address channel.
- m_axi_ar{valid,ready}  out/in  1/1  read address handshake.
- m_axi_r{data,resp,last,valid}  in  AXI_DATA_W/2/1/1  read data channel.
- m_axi_rready  out  1  read data ready.

Behaviour:
- Reset: state IDLE. All valids, readies, done and err are 0. Counters, aw_done and err_acc are 0. Reset mid-burst abandons the transaction immediately, with no cleanup beats.
- States: IDLE, WADDR, WRESP, RADDR, RDATA.
- IDLE:
  - req_rdy=1. On acceptance, latch adr, len, wrap and wr.
  - Next state is WADDR if wr, otherwise RADDR. There is no AXI activity in the acceptance cycle.
- Channel fields:
  - a*len = latched len, zero-extended to 8 bits.
  - a*size = log2(AXI_DATA_W/8).
  - a*burst = 2'b10 if wrap and len is in {1,3,7,15}. Otherwise 2'b01, and an illegal wrap length forces err=1 at done.
  - a*addr = latched address.
  - Cache, prot, lock and qos are not ported; the interconnect ties them off.
- WADDR (AW and W concurrent):
  - m_axi_awvalid = ~aw_done. aw_done is set on aw handshake.
  - m_axi_wvalid = wd_val & (bcnt<=len). wd_rdy = m_axi_wready & (bcnt<=len).
  - wdata and wstrb pass straight through combinationally.
  - m_axi_wlast = (bcnt==len). bcnt increments on each w handshake.
  - W beats may complete before, with, or after the AW handshake.
  - When aw_done (or the AW handshake this cycle) and the last W handshake have both happened, go to WRESP.
- WRESP: bready=1. On b handshake: done=1, err = bresp[1] | illegal_wrap, state IDLE, counters cleared.
- RADDR: arvalid=1 until ar handshake, then RDATA.
- RDATA:
  - m_axi_rready = rd_rdy. rd_val = m_axi_rvalid. rd_dat = rdata, rd_last = rlast, both combinational.
  - Each r handshake increments bcnt. err_acc |= rresp[1] | (rlast != (bcnt==len)).
  - The r handshake with rlast=1 ends the burst: done, err = err_acc | illegal_wrap, state IDLE.
  - A burst where bcnt reaches len without rlast keeps accepting beats until rlast; err is set.
- done is never asserted in the same cycle as req_rdy acceptance. A new request is accepted no earlier than the cycle after done.
- Minimum latency, zero-wait slave:
  - Single-beat write: accept at cycle 0, AW/W handshakes at cycle 1, B at cycle 2, done at cycle 2.
  - Single-beat read: accept at cycle 0, AR at cycle 1, R at cycle 2, done at cycle 2.

Test Plan:
- Write 1 beat, adr 0x100, data 0xDEADBEEF, stb 0xF, zero-wait slave -> AW len 0 burst 01 size 2, wlast=1, done at cycle 2, err 0.
- Read INCR len 3 at 0x200; slave returns 0x0..0x3; rd_rdy low every other cycle -> 4 beats in order, rd_last only on 0x3, no beats lost, done with err 0.
- Write WRAP len 7 at 0x1C; wready high and awready held low for 10 cycles -> all 8 W beats accepted first, awburst 10, one AW, done after B, err 0.
- Write with bresp=2'b10 (SLVERR) -> done with err 1. A new request accepted the next cycle proceeds normally.
- Read len 3, slave asserts rlast on beat 2 -> burst ends after 3 beats, done with err 1. Separately, req_wrap=1 with len 2 -> burst 01 issued, err 1.
- Assert rst during beat 2 of an 8-beat read -> same cycle all valids and readies are 0 and req_rdy=0. After rst deasserts: req_rdy=1, done=0, and the next request issues ar len from its own req_len.

Source files
------------

// File: rtl/axi4m_burst.sv
// Native-request to AXI4 burst master: one INCR/WRAP burst per request, beat-by-beat
// write/read streaming with AXI error and beat-count mismatch reporting.
module axi4m_burst #(
  parameter int AXI_ADDR_W = 32,
  parameter int AXI_DATA_W = 32,
  parameter int MAX_BEATS  = 16,
  parameter int LEN_W      = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    req_val,
  output logic                    req_rdy,
  input  logic [AXI_ADDR_W-1:0]   req_adr,
  input  logic                    req_wr,
  input  logic [LEN_W-1:0]        req_len,
  input  logic                    req_wrap,
  input  logic                    wd_val,
  output logic                    wd_rdy,
  input  logic [AXI_DATA_W-1:0]   wd_dat,
  input  logic [AXI_DATA_W/8-1:0] wd_stb,
  output logic                    rd_val,
  input  logic                    rd_rdy,
  output logic [AXI_DATA_W-1:0]   rd_dat,
  output logic                    rd_last,
  output logic                    done,
  output logic                    err,
  output logic [AXI_ADDR_W-1:0]   m_axi_awaddr,
  output logic [7:0]              m_axi_awlen,
  output logic [2:0]              m_axi_awsize,
  output logic [1:0]              m_axi_awburst,
  output logic                    m_axi_awvalid,
  input  logic                    m_axi_awready,
  output logic [AXI_DATA_W-1:0]   m_axi_wdata,
  output logic [AXI_DATA_W/8-1:0] m_axi_wstrb,
  output logic                    m_axi_wlast,
  output logic                    m_axi_wvalid,
  input  logic                    m_axi_wready,
  input  logic [1:0]              m_axi_bresp,
  input  logic                    m_axi_bvalid,
  output logic                    m_axi_bready,
  output logic [AXI_ADDR_W-1:0]   m_axi_araddr,
  output logic [7:0]              m_axi_arlen,
  output logic [2:0]              m_axi_arsize,
  output logic [1:0]              m_axi_arburst,
  output logic                    m_axi_arvalid,
  input  logic                    m_axi_arready,
  input  logic [AXI_DATA_W-1:0]   m_axi_rdata,
  input  logic [1:0]              m_axi_rresp,
  input  logic                    m_axi_rlast,
  input  logic                    m_axi_rvalid,
  output logic                    m_axi_rready
);

  typedef enum logic [2:0] {IDLE, WADDR, WRESP, RADDR, RDATA} state_t;

  localparam int         BCNT_W = $clog2(MAX_BEATS) + 1;
  localparam logic [2:0] SIZE   = 3'($clog2(AXI_DATA_W / 8));

  state_t                state_q, state_d;
  logic [AXI_ADDR_W-1:0] adr_q;
  logic [LEN_W-1:0]      len_q;
  logic                  wrap_q;
  logic [BCNT_W-1:0]     bcnt_q, bcnt_d;
  logic                  aw_done_q, aw_done_d;
  logic                  err_acc_q, err_acc_d;

  logic [7:0]        len8;
  logic [BCNT_W-1:0] len_ext;
  logic              wrap_legal, illegal_wrap;
  logic              w_open, beat_last;
  logic              aw_fire, w_fire, beat_err;
  logic              unused_resp;

  assign len8         = 8'(len_q);
  assign len_ext      = BCNT_W'(len_q);
  assign wrap_legal   = (len8 == 8'd1) || (len8 == 8'd3) || (len8 == 8'd7) || (len8 == 8'd15);
  assign illegal_wrap = wrap_q & ~wrap_legal;
  assign w_open       = (bcnt_q <= len_ext);
  assign beat_last    = (bcnt_q == len_ext);
  assign unused_resp  = ^{m_axi_bresp[0], m_axi_rresp[0]};

  // Both address channels carry the same latched request fields.
  assign m_axi_awaddr  = adr_q;
  assign m_axi_awlen   = len8;
  assign m_axi_awsize  = SIZE;
  assign m_axi_awburst = (wrap_q && wrap_legal) ? 2'b10 : 2'b01;
  assign m_axi_araddr  = adr_q;
  assign m_axi_arlen   = len8;
  assign m_axi_arsize  = SIZE;
  assign m_axi_arburst = m_axi_awburst;
  assign m_axi_wdata   = wd_dat;
  assign m_axi_wstrb   = wd_stb;
  assign rd_dat        = m_axi_rdata;
  assign rd_last       = m_axi_rlast;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      adr_q     <= '0;
      len_q     <= '0;
      wrap_q    <= 1'b0;
      bcnt_q    <= '0;
      aw_done_q <= 1'b0;
      err_acc_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      bcnt_q    <= bcnt_d;
      aw_done_q <= aw_done_d;
      err_acc_q <= err_acc_d;
      if (state_q == IDLE && req_val) begin
        adr_q  <= req_adr;
        len_q  <= req_len;
        wrap_q <= req_wrap;
      end
    end
  end

  always_comb begin
    state_d       = state_q;
    bcnt_d        = bcnt_q;
    aw_done_d     = aw_done_q;
    err_acc_d     = err_acc_q;
    req_rdy       = 1'b0;
    wd_rdy        = 1'b0;
    rd_val        = 1'b0;
    done          = 1'b0;
    err           = 1'b0;
    m_axi_awvalid = 1'b0;
    m_axi_wvalid  = 1'b0;
    m_axi_wlast   = 1'b0;
    m_axi_bready  = 1'b0;
    m_axi_arvalid = 1'b0;
    m_axi_rready  = 1'b0;
    aw_fire       = 1'b0;
    w_fire        = 1'b0;
    beat_err      = 1'b0;
    unique case (state_q)
      IDLE: begin
        req_rdy = ~rst;
        if (req_val && !rst) begin
          state_d = req_wr ? WADDR : RADDR;
        end
      end
      WADDR: begin
        m_axi_awvalid = ~aw_done_q;
        m_axi_wvalid  = wd_val & w_open;
        wd_rdy        = m_axi_wready & w_open;
        m_axi_wlast   = beat_last;
        aw_fire       = m_axi_awvalid & m_axi_awready;
        w_fire        = m_axi_wvalid & m_axi_wready;
        if (aw_fire) aw_done_d = 1'b1;
        if (w_fire)  bcnt_d    = bcnt_q + 1'b1;
        // AW may land before, with or after the final W beat.
        if ((aw_done_q || aw_fire) && (!w_open || (w_fire && beat_last))) begin
          state_d = WRESP;
        end
      end
      WRESP: begin
        m_axi_bready = 1'b1;
        if (m_axi_bvalid) begin
          done      = 1'b1;
          err       = m_axi_bresp[1] | illegal_wrap;
          state_d   = IDLE;
          bcnt_d    = '0;
          aw_done_d = 1'b0;
          err_acc_d = 1'b0;
        end
      end
      RADDR: begin
        m_axi_arvalid = 1'b1;
        if (m_axi_arready) state_d = RDATA;
      end
      RDATA: begin
        m_axi_rready = rd_rdy;
        rd_val       = m_axi_rvalid;
        if (m_axi_rvalid && rd_rdy) begin
          beat_err  = m_axi_rresp[1] | (m_axi_rlast != beat_last);
          err_acc_d = err_acc_q | beat_err;
          // Saturate so an overlong burst cannot wrap back onto len.
          if (bcnt_q != '1) bcnt_d = bcnt_q + 1'b1;
          if (m_axi_rlast) begin
            done      = 1'b1;
            err       = err_acc_q | beat_err | illegal_wrap;
            state_d   = IDLE;
            bcnt_d    = '0;
            aw_done_d = 1'b0;
            err_acc_d = 1'b0;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

endmodule
